// File: rtl/decoder_pipe.sv
// decoder_pipe: RV32I instruction decoder followed by a registered valid/ready
// output stage with flush, PC/tag passthrough and a saturating count of
// illegal instructions accepted.
// Optional macro DECODER_RV32M_EN: decode the RV32M multiply/divide encodings
// (types 37-44). Without it those encodings are treated as illegal.
module decoder_pipe #(
   parameter int WIDTH     = 32,
   parameter int REG_WIDTH = 5,
   parameter int TYPE_W    = 9,
   parameter int TAG_W     = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     inst,
   input  logic [WIDTH-1:0]     in_pc,
   input  logic [TAG_W-1:0]     in_tag,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [TYPE_W-1:0]    instr_type,
   output logic [WIDTH-1:0]     imm,
   output logic [REG_WIDTH-1:0] rs1,
   output logic [REG_WIDTH-1:0] rs2,
   output logic [REG_WIDTH-1:0] rd,
   output logic                 rs1e,
   output logic                 rs2e,
   output logic                 rde,
   output logic                 illegal,
   output logic [WIDTH-1:0]     out_pc,
   output logic [TAG_W-1:0]     out_tag,
   output logic [CNT_W-1:0]     illegal_cnt
);

   if (WIDTH != 32) begin : g_width_check
      $error("decoder_pipe: only WIDTH=32 is supported");
   end
   if (TYPE_W < 6) begin : g_type_check
      $error("decoder_pipe: TYPE_W must be at least 6");
   end

   localparam logic [TYPE_W-1:0] T_LUI   = TYPE_W'(6);
   localparam logic [TYPE_W-1:0] T_AUIPC = TYPE_W'(7);
   localparam logic [TYPE_W-1:0] T_JAL   = TYPE_W'(8);
   localparam logic [TYPE_W-1:0] T_JALR  = TYPE_W'(9);
   localparam logic [TYPE_W-1:0] T_BEQ   = TYPE_W'(10);
   localparam logic [TYPE_W-1:0] T_BNE   = TYPE_W'(11);
   localparam logic [TYPE_W-1:0] T_BLT   = TYPE_W'(12);
   localparam logic [TYPE_W-1:0] T_BGE   = TYPE_W'(13);
   localparam logic [TYPE_W-1:0] T_BLTU  = TYPE_W'(14);
   localparam logic [TYPE_W-1:0] T_BGEU  = TYPE_W'(15);
   localparam logic [TYPE_W-1:0] T_ADDI  = TYPE_W'(16);
   localparam logic [TYPE_W-1:0] T_SLTI  = TYPE_W'(17);
   localparam logic [TYPE_W-1:0] T_SLTIU = TYPE_W'(18);
   localparam logic [TYPE_W-1:0] T_XORI  = TYPE_W'(19);
   localparam logic [TYPE_W-1:0] T_ORI   = TYPE_W'(20);
   localparam logic [TYPE_W-1:0] T_ANDI  = TYPE_W'(21);
   localparam logic [TYPE_W-1:0] T_SLLI  = TYPE_W'(22);
   localparam logic [TYPE_W-1:0] T_SRLI  = TYPE_W'(23);
   localparam logic [TYPE_W-1:0] T_SRAI  = TYPE_W'(24);
   localparam logic [TYPE_W-1:0] T_ADD   = TYPE_W'(25);
   localparam logic [TYPE_W-1:0] T_SUB   = TYPE_W'(26);
   localparam logic [TYPE_W-1:0] T_SLL   = TYPE_W'(27);
   localparam logic [TYPE_W-1:0] T_SLT   = TYPE_W'(28);
   localparam logic [TYPE_W-1:0] T_SLTU  = TYPE_W'(29);
   localparam logic [TYPE_W-1:0] T_XOR   = TYPE_W'(30);
   localparam logic [TYPE_W-1:0] T_SRL   = TYPE_W'(31);
   localparam logic [TYPE_W-1:0] T_SRA   = TYPE_W'(32);
   localparam logic [TYPE_W-1:0] T_OR    = TYPE_W'(33);
   localparam logic [TYPE_W-1:0] T_AND   = TYPE_W'(34);
   localparam logic [TYPE_W-1:0] T_LOAD  = TYPE_W'(35);
   localparam logic [TYPE_W-1:0] T_STORE = TYPE_W'(36);
`ifdef DECODER_RV32M_EN
   localparam logic [TYPE_W-1:0] T_MUL   = TYPE_W'(37);
`endif

   // Instruction format selects enables and immediate; FMT_SH is the
   // I-type shift whose immediate is the zero-extended shift amount.
   typedef enum logic [2:0] {
      FMT_ILL, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
   } fmt_e;

   fmt_e              fmt;
   logic [TYPE_W-1:0] dec_type;
   logic [31:0]       dec_imm;
   logic              dec_rs1e, dec_rs2e, dec_rde, dec_illegal;
   logic              accept;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {inst[31:12], 12'b0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign imm_sh = {27'b0, inst[24:20]};

   // Classify the instruction: pick its type code and format, or flag it illegal.
   always_comb begin
      fmt      = FMT_ILL;
      dec_type = '1;
      case (opcode)
         7'b0110111: begin fmt = FMT_U; dec_type = T_LUI;   end
         7'b0010111: begin fmt = FMT_U; dec_type = T_AUIPC; end
         7'b1101111: begin fmt = FMT_J; dec_type = T_JAL;   end
         7'b1100111: begin
            if (funct3 == 3'b000) begin fmt = FMT_I; dec_type = T_JALR; end
         end
         7'b1100011: begin
            fmt = FMT_B;
            case (funct3)
               3'b000:  dec_type = T_BEQ;
               3'b001:  dec_type = T_BNE;
               3'b100:  dec_type = T_BLT;
               3'b101:  dec_type = T_BGE;
               3'b110:  dec_type = T_BLTU;
               3'b111:  dec_type = T_BGEU;
               default: fmt = FMT_ILL;
            endcase
         end
         7'b0000011: begin
            if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
               fmt = FMT_I; dec_type = T_LOAD;
            end
         end
         7'b0100011: begin
            if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
               fmt = FMT_S; dec_type = T_STORE;
            end
         end
         7'b0010011: begin
            fmt = FMT_I;
            case (funct3)
               3'b000: dec_type = T_ADDI;
               3'b010: dec_type = T_SLTI;
               3'b011: dec_type = T_SLTIU;
               3'b100: dec_type = T_XORI;
               3'b110: dec_type = T_ORI;
               3'b111: dec_type = T_ANDI;
               3'b001: begin
                  dec_type = T_SLLI;
                  fmt = (funct7 == 7'b0000000) ? FMT_SH : FMT_ILL;
               end
               default: begin
                  if (funct7 == 7'b0000000) begin fmt = FMT_SH; dec_type = T_SRLI; end
                  else if (funct7 == 7'b0100000) begin fmt = FMT_SH; dec_type = T_SRAI; end
                  else fmt = FMT_ILL;
               end
            endcase
         end
         7'b0110011: begin
            fmt = FMT_R;
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000: dec_type = T_ADD;
                  3'b001: dec_type = T_SLL;
                  3'b010: dec_type = T_SLT;
                  3'b011: dec_type = T_SLTU;
                  3'b100: dec_type = T_XOR;
                  3'b101: dec_type = T_SRL;
                  3'b110: dec_type = T_OR;
                  default: dec_type = T_AND;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               dec_type = T_SUB;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
               dec_type = T_SRA;
`ifdef DECODER_RV32M_EN
            end else if (funct7 == 7'b0000001) begin
               dec_type = T_MUL + TYPE_W'(funct3);
`endif
            end else begin
               fmt = FMT_ILL;
            end
         end
         default: fmt = FMT_ILL;
      endcase
      if (fmt == FMT_ILL) dec_type = '1;
   end

   // Derive register enables and the immediate from the instruction format.
   always_comb begin
      dec_rs1e = 1'b0;
      dec_rs2e = 1'b0;
      dec_rde  = 1'b0;
      dec_imm  = '0;
      case (fmt)
         FMT_R:  begin dec_rs1e = 1'b1; dec_rs2e = 1'b1; dec_rde = 1'b1; end
         FMT_I:  begin dec_rs1e = 1'b1; dec_rde = 1'b1; dec_imm = imm_i;  end
         FMT_SH: begin dec_rs1e = 1'b1; dec_rde = 1'b1; dec_imm = imm_sh; end
         FMT_S:  begin dec_rs1e = 1'b1; dec_rs2e = 1'b1; dec_imm = imm_s; end
         FMT_B:  begin dec_rs1e = 1'b1; dec_rs2e = 1'b1; dec_imm = imm_b; end
         FMT_U:  begin dec_rde = 1'b1; dec_imm = imm_u; end
         FMT_J:  begin dec_rde = 1'b1; dec_imm = imm_j; end
         default: ;
      endcase
   end

   assign dec_illegal = (fmt == FMT_ILL);

   logic                 out_valid_q, out_valid_d;
   logic [TYPE_W-1:0]    type_q, type_d;
   logic [WIDTH-1:0]     imm_q, imm_d;
   logic [REG_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic                 rs1e_q, rs1e_d, rs2e_q, rs2e_d, rde_q, rde_d;
   logic                 illegal_q, illegal_d;
   logic [WIDTH-1:0]     pc_q, pc_d;
   logic [TAG_W-1:0]     tag_q, tag_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   // Output stage: flush drops the held entry, accept loads a new one,
   // a completed out-transfer empties the stage; the counter saturates.
   always_comb begin
      out_valid_d = out_valid_q;
      type_d      = type_q;
      imm_d       = imm_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      rs1e_d      = rs1e_q;
      rs2e_d      = rs2e_q;
      rde_d       = rde_q;
      illegal_d   = illegal_q;
      pc_d        = pc_q;
      tag_d       = tag_q;
      cnt_d       = cnt_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         type_d      = dec_type;
         imm_d       = dec_imm;
         rs1_d       = REG_WIDTH'(inst[19:15]);
         rs2_d       = REG_WIDTH'(inst[24:20]);
         rd_d        = REG_WIDTH'(inst[11:7]);
         rs1e_d      = dec_rs1e;
         rs2e_d      = dec_rs2e;
         rde_d       = dec_rde;
         illegal_d   = dec_illegal;
         pc_d        = in_pc;
         tag_d       = in_tag;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept && dec_illegal && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
   end

   // Stage registers with synchronous reset clearing everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         type_q      <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         rs1e_q      <= 1'b0;
         rs2e_q      <= 1'b0;
         rde_q       <= 1'b0;
         illegal_q   <= 1'b0;
         pc_q        <= '0;
         tag_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         type_q      <= type_d;
         imm_q       <= imm_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         rs1e_q      <= rs1e_d;
         rs2e_q      <= rs2e_d;
         rde_q       <= rde_d;
         illegal_q   <= illegal_d;
         pc_q        <= pc_d;
         tag_q       <= tag_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign instr_type  = type_q;
   assign imm         = imm_q;
   assign rs1         = rs1_q;
   assign rs2         = rs2_q;
   assign rd          = rd_q;
   assign rs1e        = rs1e_q;
   assign rs2e        = rs2e_q;
   assign rde         = rde_q;
   assign illegal     = illegal_q;
   assign out_pc      = pc_q;
   assign out_tag     = tag_q;
   assign illegal_cnt = cnt_q;

endmodule
